kgp_cycle_ctrl: RTL and testbench
=================================

# kgp_cycle_ctrl

Multi-cycle control sequencer for the KGP-miniRISC core. Steps each instruction through fetch, decode, execute, memory and write-back, and drives the datapath register strobes (PC, IR, register file) plus memory and multi-cycle ALU handshakes. Sits between the instruction decoder (which supplies an op class) and the flip-flop/register datapath. Counts retired instructions and halts on a HALT op, an illegal op or a memory timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum consecutive mem_req cycles without mem_ack before a timeout error (≥2).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (rst=0 resets).
- start  in  1  leaves IDLE; ignored in all other states.
- op_class  in  3  decoder output, sampled only in DECODE: 0 ALU, 1 ALU_MC, 2 LOAD, 3 STORE, 4 BRANCH, 5 HALT, 6 NOP, 7 illegal.
- mem_ack  in  1  memory completion, valid only while mem_req=1.
- alu_done  in  1  multi-cycle ALU completion, valid only in EXEC for ALU_MC.
- pc_we  out  1  PC write strobe.
- ir_we  out  1  instruction register write strobe.
- rf_we  out  1  register file write strobe.
- mem_req  out  1  memory request, level.
- mem_we  out  1  1 = write, 0 = read; qualifies mem_req.
- alu_start  out  1  one-cycle pulse launching the multi-cycle ALU.
- state  out  3  current state code.
- busy  out  1  1 in every state except IDLE and HALT.
- err  out  1  sticky error flag.
- instr_cnt  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W.

## Operation
- States/codes: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, WB 5, HALT 6. Code 7 unreachable; if entered, go to HALT with err=1.
- IDLE: strobes 0; start=1 → FETCH.
- FETCH: mem_req=1, mem_we=0. On mem_ack: ir_we=1 and pc_we=1 in that cycle (combinational on ack), → DECODE.
- DECODE (1 cycle): ALU → EXEC; ALU_MC → EXEC with mc flag set; LOAD → MEM (read); STORE → MEM (write); BRANCH → pc_we=1, retire, → FETCH; NOP → retire, → FETCH; HALT → retire, → HALT; illegal → err=1, → HALT (not retired).
- EXEC: ALU: one cycle → WB. ALU_MC: alu_start=1 in the first EXEC cycle only; wait for alu_done, then → WB. alu_done in the first cycle is accepted.
- MEM: mem_req=1, mem_we=1 for STORE. On mem_ack: LOAD → WB; STORE → retire, → FETCH.
- WB: rf_we=1 for one cycle, retire, → FETCH.
- HALT: all strobes 0, busy=0; exits only through reset.
- Timeout: wait counter cleared on entering FETCH/MEM, +1 per unacked cycle. If the MEM_TIMEOUT-th request cycle has no ack: err=1, → HALT, mem_req drops next cycle. Ack in that same cycle wins (no error).
- Retire = instr_cnt+1 on the transition cycle; 2^CNT_W−1 wraps to 0.
- mem_ack outside FETCH/MEM and alu_done outside EXEC are ignored.

## Timing
- Reset (rst=0, async): state=IDLE, every strobe 0, busy=0, err=0, instr_cnt=0, wait counter 0, mc flag 0. Applies immediately mid-instruction; an in-flight memory request is abandoned.
- Strobes are Moore outputs of state, except ir_we/pc_we in FETCH (gated by mem_ack) and the DECODE strobes (decoded from op_class).
- Minimum latency with same-cycle ack: ALU 4 cycles, LOAD 4, STORE 3, BRANCH/NOP 2, ALU_MC 4 + alu_done wait.
- start→FETCH: one cycle; mem_req is high the cycle after start.

## Structure
- Shared package kgp_ctrl_pkg: state codes, op_class codes, default MEM_TIMEOUT.
- One sub-module: kgp_wait_timer (clear, enable, ack; outputs expire at MEM_TIMEOUT). Used for FETCH and MEM waits.
- FSM as state register plus combinational next-state/output logic.

## Test plan
- Reset mid-FETCH: rst=0 while mem_req=1 → all outputs 0 same cycle, state=0, instr_cnt=0.
- start, ALU op, ack same cycle → FETCH,DECODE,EXEC,WB; rf_we in cycle 4 only; instr_cnt=1.
- LOAD, ack delayed 3 cycles in MEM → mem_req held 3 cycles with mem_we=0, then WB, rf_we 1 cycle.
- ALU_MC, alu_done after 5 cycles → alu_start high exactly 1 cycle, WB follows done.
- No ack for 15 FETCH cycles → err=1, state=6, busy=0; repeat with ack on cycle 15 → no error.
- op_class=7 → err=1, HALT, instr_cnt unchanged; counter preset 0xFFFF then NOP → 0x0000.

Source files
------------

// File: rtl/kgp_ctrl_pkg.sv
// kgp_ctrl_pkg: shared state codes, op classes and defaults for the KGP-miniRISC control sequencer
package kgp_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_BAD    = 3'd7
  } state_e;
  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_ALU_MC = 3'd1,
    OP_LOAD   = 3'd2,
    OP_STORE  = 3'd3,
    OP_BRANCH = 3'd4,
    OP_HALT   = 3'd5,
    OP_NOP    = 3'd6,
    OP_ILL    = 3'd7
  } op_e;
  localparam int MEM_TIMEOUT_DEF = 15;
endpackage

// File: rtl/kgp_wait_timer.sv
// kgp_wait_timer: counts unacknowledged memory request cycles and flags the last allowed one
module kgp_wait_timer
  import kgp_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic ack_i,
  output logic expire_o
);
  localparam int W = $clog2(MEM_TIMEOUT);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);
  logic [W-1:0] cnt_q, cnt_d;
  // count holds k-1 during the k-th request cycle, so expiry is the MEM_TIMEOUT-th unacked cycle
  always_comb begin
    cnt_d    = (clr_i || ack_i) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    expire_o = en_i && !ack_i && cnt_q == LAST;
  end
  // wait counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/kgp_cycle_ctrl.sv
// kgp_cycle_ctrl: multi-cycle fetch/decode/execute/memory/write-back sequencer with retire counter
module kgp_cycle_ctrl
  import kgp_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op_class,
  input  logic             mem_ack,
  input  logic             alu_done,
  output logic             pc_we,
  output logic             ir_we,
  output logic             rf_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             alu_start,
  output logic [2:0]       state,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);
  state_e           state_q, state_d;
  op_e              op;
  logic             mc_q, mc_d, st_q, st_d, first_q, first_d, err_q, err_d;
  logic             retire, waiting, expire;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign op      = op_e'(op_class);
  assign waiting = state_q == S_FETCH || state_q == S_MEM;

  kgp_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (!waiting),
    .en_i    (waiting),
    .ack_i   (mem_ack),
    .expire_o(expire)
  );

  // next-state, datapath strobes and retire decision
  always_comb begin
    state_d   = state_q;
    mc_d      = mc_q;
    st_d      = st_q;
    first_d   = 1'b0;
    err_d     = err_q;
    retire    = 1'b0;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    alu_start = 1'b0;
    case (state_q)
      S_IDLE: state_d = start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ack;
        pc_we   = mem_ack;
        if (mem_ack) state_d = S_DECODE;
        else if (expire) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_DECODE: begin
        mc_d = op == OP_ALU_MC;
        st_d = op == OP_STORE;
        case (op)
          OP_ALU, OP_ALU_MC: begin
            first_d = 1'b1;
            state_d = S_EXEC;
          end
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH: begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_NOP: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          OP_HALT: begin
            retire  = 1'b1;
            state_d = S_HALT;
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        alu_start = mc_q && first_q;
        if (!mc_q || alu_done) state_d = S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = st_q;
        if (mem_ack) begin
          retire  = st_q;
          state_d = st_q ? S_FETCH : S_WB;
        end else if (expire) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        err_d   = 1'b1;
        state_d = S_HALT;
      end
    endcase
    cnt_d = retire ? cnt_q + 1'b1 : cnt_q;
  end

  // state, instruction flags, sticky error and retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mc_q    <= 1'b0;
      st_q    <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      st_q    <= st_d;
      first_q <= first_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state     = state_q;
  assign busy      = !(state_q == S_IDLE || state_q == S_HALT);
  assign err       = err_q;
  assign instr_cnt = cnt_q;
endmodule

// File: tb/tb_kgp_cycle_ctrl.sv
// tb_kgp_cycle_ctrl: directed scoreboard bench for the cycle sequencer
module tb_kgp_cycle_ctrl;
  import kgp_ctrl_pkg::*;
  localparam int CW = 4;
  logic clk = 1'b0, rst, start, mem_ack, alu_done;
  logic [2:0] op_class, state;
  logic pc_we, ir_we, rf_we, mem_req, mem_we, alu_start, busy, err;
  logic [CW-1:0] instr_cnt;
  logic [CW-1:0] ecnt = '0;
  logic eerr = 1'b0;
  logic done = 1'b0;
  string qn[$];
  logic [14:0] qv[$];
  int checks = 0, failures = 0;

  kgp_cycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .op_class(op_class), .mem_ack(mem_ack),
    .alu_done(alu_done), .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .mem_req(mem_req),
    .mem_we(mem_we), .alu_start(alu_start), .state(state), .busy(busy), .err(err),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // sb = {pc_we, ir_we, rf_we, mem_req, mem_we, alu_start}; expectation covers the current cycle
  task automatic cyc(input string nm, input logic [2:0] st, input logic [5:0] sb);
    logic bz;
    bz = st != 3'd0 && st != 3'd6;
    qn.push_back(nm);
    qv.push_back({st, sb, bz, eerr, ecnt});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) begin
      mem_ack = 1'b0;
      cyc("fetch_wait", 3'd1, 6'b000100);
    end
    mem_ack = 1'b1;
    cyc("fetch_ack", 3'd1, 6'b110100);
    mem_ack = 1'b0;
  endtask

  task automatic dec(input logic [2:0] op, input logic [5:0] sb);
    op_class = op;
    cyc("decode", 3'd2, sb);
    op_class = 3'd0;
  endtask

  task automatic go(input string nm);
    start = 1'b1;
    cyc(nm, 3'd0, 6'b0);
    start = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    rst  = 1'b0;
    eerr = 1'b0;
    ecnt = '0;
    cyc(nm, 3'd0, 6'b0);
    rst = 1'b1;
  endtask

  // stimulus: each cyc() pushes the expected outputs for the cycle it drives
  initial begin
    rst = 1'b0; start = 1'b0; op_class = 3'd0; mem_ack = 1'b0; alu_done = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", 3'd0, 6'b0);
    rst = 1'b1;
    cyc("idle", 3'd0, 6'b0);
    go("start");
    cyc("fetch_req", 3'd1, 6'b000100);
    do_reset("reset_mid_fetch");
    cyc("idle_after_reset", 3'd0, 6'b0);
    go("start_alu");
    fetch(0); dec(OP_ALU, 6'b0);
    cyc("exec_alu", 3'd3, 6'b0);
    cyc("wb_alu", 3'd5, 6'b001000); ecnt = ecnt + 1'b1;
    fetch(0); dec(OP_LOAD, 6'b0);
    cyc("mem_ld_wait", 3'd4, 6'b000100);
    cyc("mem_ld_wait", 3'd4, 6'b000100);
    mem_ack = 1'b1; cyc("mem_ld_ack", 3'd4, 6'b000100); mem_ack = 1'b0;
    cyc("wb_ld", 3'd5, 6'b001000); ecnt = ecnt + 1'b1;
    fetch(1); dec(OP_STORE, 6'b0);
    mem_ack = 1'b1; cyc("mem_st_ack", 3'd4, 6'b000110); mem_ack = 1'b0; ecnt = ecnt + 1'b1;
    alu_done = 1'b1;
    fetch(0); dec(OP_ALU_MC, 6'b0);
    alu_done = 1'b0;
    cyc("mc_start", 3'd3, 6'b000001);
    repeat (4) cyc("mc_wait", 3'd3, 6'b0);
    alu_done = 1'b1; cyc("mc_done", 3'd3, 6'b0); alu_done = 1'b0;
    cyc("wb_mc", 3'd5, 6'b001000); ecnt = ecnt + 1'b1;
    fetch(0); dec(OP_ALU_MC, 6'b0);
    alu_done = 1'b1; cyc("mc_first_done", 3'd3, 6'b000001); alu_done = 1'b0;
    cyc("wb_mc_fast", 3'd5, 6'b001000); ecnt = ecnt + 1'b1;
    fetch(0); dec(OP_BRANCH, 6'b100000); ecnt = ecnt + 1'b1;
    fetch(14); dec(OP_NOP, 6'b0); ecnt = ecnt + 1'b1;
    for (int i = 0; i < 9; i++) begin
      fetch(0); dec(OP_NOP, 6'b0); ecnt = ecnt + 1'b1;
    end
    repeat (15) cyc("fetch_timeout", 3'd1, 6'b000100);
    eerr = 1'b1;
    cyc("halt_timeout", 3'd6, 6'b0);
    start = 1'b1; mem_ack = 1'b1; alu_done = 1'b1;
    cyc("halt_stays", 3'd6, 6'b0);
    start = 1'b0; mem_ack = 1'b0; alu_done = 1'b0;
    do_reset("reset_after_halt");
    go("start_ill");
    fetch(0); dec(OP_NOP, 6'b0); ecnt = ecnt + 1'b1;
    fetch(0); dec(OP_ILL, 6'b0); eerr = 1'b1;
    cyc("halt_illegal", 3'd6, 6'b0);
    do_reset("reset_before_haltop");
    go("start_halt");
    fetch(0); dec(OP_HALT, 6'b0); ecnt = ecnt + 1'b1;
    cyc("halt_op", 3'd6, 6'b0);
    do_reset("reset_before_memto");
    go("start_memto");
    fetch(0); dec(OP_STORE, 6'b0);
    repeat (15) cyc("mem_timeout", 3'd4, 6'b000110);
    eerr = 1'b1;
    cyc("halt_mem_timeout", 3'd6, 6'b0);
    done = 1'b1;
  end

  // monitor: pops one expectation per cycle and compares against the live outputs
  initial begin
    logic [14:0] act, exp_v;
    string nm;
    int ncyc = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (qv.size() > 0) begin
        exp_v = qv.pop_front();
        nm    = qn.pop_front();
        act   = {state, pc_we, ir_we, rf_we, mem_req, mem_we, alu_start, busy, err, instr_cnt};
        checks++;
        if (act !== exp_v) begin
          failures++;
          $display("FAIL %s @%0t: got {st,pc,ir,rf,req,we,as,busy,err,cnt}=%b_%b_%b_%b_%h want %b_%b_%b_%b_%h",
                   nm, $time, act[14:12], act[11:6], act[5], act[4], act[3:0],
                   exp_v[14:12], exp_v[11:6], exp_v[5], exp_v[4], exp_v[3:0]);
        end
      end else if (done || ncyc > 4000) begin
        if (!done) begin
          failures++;
          $display("FAIL watchdog: got %0d cycles without completion, want at most 4000", ncyc);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end
endmodule
